gcd_operand_sequencer: RTL and testbench
========================================

// Module: gcd_operand_sequencer
// PURPOSE
//  Upstream front-end of the GCD engine (gcd_control + gcd_data). Accepts an operand pair via valid/ready.
//  Serialises it onto the engine's shared data_in bus with the start pulse, waits for finish,
//  captures the result and returns it via valid/ready.
//  Short-circuits zero operands, which would stall the subtractive engine.
// PARAMETERS
//  WIDTH           16    operand/result width; equals engine data_in width
//  TIMEOUT_CYCLES  1024  max cycles in WAIT before abort (used only with GCD_SEQ_TIMEOUT_EN)
// PORTS
//  clock        in   1      single clock, all state on rising edge
//  reset_n      in   1      asynchronous, active-low reset
//  op_valid     in   1      operand pair offered
//  op_ready     out  1      sequencer can accept pair (IDLE only)
//  op_a         in   WIDTH  operand A
//  op_b         in   WIDTH  operand B
//  gcd_start    out  1      one-cycle start pulse to engine control path
//  gcd_data_in  out  WIDTH  engine data_in bus
//  gcd_finish   in   1      engine done flag
//  gcd_result   in   WIDTH  engine A register (holds GCD when finish=1)
//  res_valid    out  1      result available
//  res_ready    in   1      consumer accepts result
//  res_data     out  WIDTH  GCD result
//  res_err      out  1      result invalid (timeout); qualified by res_valid
// BEHAVIOUR
//  Reset: state=IDLE, op_ready=1, gcd_start=0, gcd_data_in=0, res_valid=0, res_data=0, res_err=0.
//  States: IDLE -> START -> SEND_A -> SEND_B -> WAIT -> DONE -> IDLE.
//  IDLE: op_ready=1. op_valid&op_ready latches op_a/op_b.
//   If either operand is 0: skip the engine and go to DONE.
//   res_data = op_b if op_a==0, else op_a (0,0 -> 0). Otherwise go to START.
//  START (1 cycle): gcd_start=1, gcd_data_in=0.
//  SEND_A (1 cycle): gcd_data_in=A. SEND_B (1 cycle): gcd_data_in=B.
//  WAIT: gcd_data_in=0. First cycle gcd_finish=1 -> capture gcd_result into res_data, go to DONE.
//   finish seen in START/SEND_A/SEND_B is stale from the previous run and is ignored.
//  DONE: res_valid=1; res_data/res_err held stable. res_valid&res_ready -> IDLE.
//   op_ready returns next cycle; no new pair is accepted in the same cycle.
//  Latency, non-zero operands: 3 cycles from accept to start of WAIT, then engine time, then +1 to res_valid.
//  Latency, zero-operand bypass: res_valid 1 cycle after accept.
//  op_ready=0 outside IDLE. op_a/op_b changes after accept have no effect.
//  reset_n low at any point: immediate return to reset values. An in-flight result is discarded.
//  All arithmetic is compare-only; no width growth.
// CONFIGURATION
//  GCD_SEQ_TIMEOUT_EN defined:
//   - WAIT has a cycle counter, cleared on entry to WAIT.
//   - Counter reaches TIMEOUT_CYCLES without finish -> DONE with res_err=1, res_data=0.
//   - gcd_start is not re-issued.
//  GCD_SEQ_TIMEOUT_EN undefined:
//   - No counter; WAIT waits indefinitely.
//   - res_err tied 0.
// STRUCTURE
//  gcd_pkg: state enum (IDLE..DONE, 3-bit), GCD_WIDTH=16 default, TIMEOUT_CYCLES default.
//  Single module. Timeout counter stays inline under the ifdef; no sub-module.
// TESTING
//  1. A=78, B=143. Required pulse/bus sequence:
//     - gcd_start pulse, then data_in 78, then data_in 143.
//     - Engine runs; res_data=13, res_valid=1, res_err=0.
//  2. A=0, B=25 -> no gcd_start; res_valid 1 cycle after accept, res_data=25.
//     A=0, B=0 -> res_data=0.
//  3. Back-pressure: hold res_ready=0 for 10 cycles after res_valid.
//     -> res_data stable, op_ready=0, op_valid ignored. Then res_ready=1 -> IDLE, op_ready=1.
//  4. Assert reset_n=0 during WAIT. Outputs go to reset values immediately.
//     Next pair A=48, B=18 -> 6.
//  5. GCD_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=8, finish held 0.
//     -> res_valid with res_err=1, res_data=0, exactly 8 cycles after WAIT entry.
//  6. Stale finish: finish=1 still asserted from the previous run during START..SEND_B.
//     -> ignored; result taken only from finish in WAIT.

Source files
------------

// File: rtl/gcd_pkg.sv
// Shared types and defaults for the GCD engine front-end sequencer.
package gcd_pkg;

  localparam int GCD_WIDTH              = 16;
  localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    SEND_A = 3'd2,
    SEND_B = 3'd3,
    WAIT   = 3'd4,
    DONE   = 3'd5
  } gcd_state_t;

endpackage

// File: rtl/gcd_operand_sequencer.sv
// Front-end for the subtractive GCD engine: serialises an operand pair onto the shared bus and returns the result.
// Optional WAIT-state abort counter is enabled by defining GCD_SEQ_TIMEOUT_EN.
module gcd_operand_sequencer
  import gcd_pkg::*;
#(
  parameter int WIDTH = GCD_WIDTH
`ifdef GCD_SEQ_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
`endif
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             gcd_start,
  output logic [WIDTH-1:0] gcd_data_in,
  input  logic             gcd_finish,
  input  logic [WIDTH-1:0] gcd_result,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_err
);

  gcd_state_t       state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;

`ifdef GCD_SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wait_cnt;
`else
  assign res_err = 1'b0;
`endif

  // Zero operands never reach the engine; finish is only trusted once WAIT is reached,
  // since the engine keeps it high from the previous run until it reloads.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      op_ready    <= 1'b1;
      gcd_start   <= 1'b0;
      gcd_data_in <= '0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
`ifdef GCD_SEQ_TIMEOUT_EN
      res_err     <= 1'b0;
      wait_cnt    <= '0;
`endif
    end else begin
      gcd_start <= 1'b0;
      case (state)
        IDLE: begin
          if (op_valid && op_ready) begin
            op_ready <= 1'b0;
            a_reg    <= op_a;
            b_reg    <= op_b;
`ifdef GCD_SEQ_TIMEOUT_EN
            res_err  <= 1'b0;
`endif
            if (op_a == '0 || op_b == '0) begin
              res_data  <= (op_a == '0) ? op_b : op_a;
              res_valid <= 1'b1;
              state     <= DONE;
            end else begin
              gcd_start   <= 1'b1;
              gcd_data_in <= '0;
              state       <= START;
            end
          end
        end
        START: begin
          gcd_data_in <= a_reg;
          state       <= SEND_A;
        end
        SEND_A: begin
          gcd_data_in <= b_reg;
          state       <= SEND_B;
        end
        SEND_B: begin
          gcd_data_in <= '0;
          state       <= WAIT;
`ifdef GCD_SEQ_TIMEOUT_EN
          wait_cnt    <= '0;
`endif
        end
        WAIT: begin
          if (gcd_finish) begin
            res_data  <= gcd_result;
            res_valid <= 1'b1;
            state     <= DONE;
          end
`ifdef GCD_SEQ_TIMEOUT_EN
          else if (wait_cnt == CNT_LAST) begin
            res_data  <= '0;
            res_err   <= 1'b1;
            res_valid <= 1'b1;
            state     <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            op_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          res_valid <= 1'b0;
          op_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_operand_sequencer.sv
// Self-checking bench for gcd_operand_sequencer with a behavioural GCD engine and a result scoreboard.
// Define GCD_SEQ_TIMEOUT_EN to also exercise the WAIT abort path.
module tb_gcd_operand_sequencer;

  localparam int W         = 16;
  localparam int ENG_DELAY = 3;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         op_valid;
  logic         op_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         gcd_start;
  logic [W-1:0] gcd_data_in;
  logic         gcd_finish;
  logic [W-1:0] gcd_result;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_data;
  logic         res_err;

  int           checks = 0;
  int           fails = 0;
  int           start_count = 0;
  logic [W:0]   exp_q[$];
  logic [W-1:0] eng_a;
  logic [W-1:0] eng_b;
  logic         hold_finish_low = 1'b0;

  gcd_operand_sequencer #(
    .WIDTH(W)
`ifdef GCD_SEQ_TIMEOUT_EN
    , .TIMEOUT_CYCLES(8)
`endif
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .op_valid(op_valid),
    .op_ready(op_ready),
    .op_a(op_a),
    .op_b(op_b),
    .gcd_start(gcd_start),
    .gcd_data_in(gcd_data_in),
    .gcd_finish(gcd_finish),
    .gcd_result(gcd_result),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data(res_data),
    .res_err(res_err)
  );

  always #5 clock = ~clock;

  function automatic logic [W-1:0] gcd_ref(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Engine model: finish stays high from the previous run until operand B has been loaded.
  initial begin
    gcd_finish = 1'b0;
    gcd_result = '0;
    forever begin
      @(negedge clock);
      if (gcd_start === 1'b1) begin
        start_count++;
        checkOutput("start_bus_zero", gcd_data_in, 0);
        @(negedge clock);
        eng_a = gcd_data_in;
        @(negedge clock);
        eng_b = gcd_data_in;
        gcd_finish = 1'b0;
        gcd_result = eng_a;
        repeat (ENG_DELAY) @(negedge clock);
        gcd_result = gcd_ref(eng_a, eng_b);
        gcd_finish = ~hold_finish_low;
      end
    end
  end

  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic timeout);
    int n;
    n = 0;
    while (op_ready !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    checkOutput("op_ready_before_accept", op_ready, 1);
    op_a     = a;
    op_b     = b;
    op_valid = 1'b1;
    @(posedge clock);
    #1;
    op_valid = 1'b0;
    op_a     = 16'hFFFF;
    op_b     = 16'h1234;
    if (timeout)
      exp_q.push_back({1'b1, {W{1'b0}}});
    else if (a == 0)
      exp_q.push_back({1'b0, b});
    else if (b == 0)
      exp_q.push_back({1'b0, a});
    else
      exp_q.push_back({1'b0, gcd_ref(a, b)});
  endtask

  task automatic waitResult(input string tag, output int n);
    logic [W:0] exp;
    n = 0;
    while (res_valid !== 1'b1 && n < 60) begin
      @(negedge clock);
      n++;
    end
    if (res_valid !== 1'b1) begin
      checkOutput({tag, "_res_valid_timeout"}, 0, 1);
      if (exp_q.size() > 0) exp = exp_q.pop_front();
    end else if (exp_q.size() == 0) begin
      checkOutput({tag, "_unexpected_result"}, 1, 0);
    end else begin
      exp = exp_q.pop_front();
      checkOutput({tag, "_data"}, res_data, exp[W-1:0]);
      checkOutput({tag, "_err"}, res_err, exp[W]);
    end
  endtask

  task automatic consume(input string tag);
    res_ready = 1'b1;
    @(posedge clock);
    #1;
    res_ready = 1'b0;
    checkOutput({tag, "_op_ready_back"}, op_ready, 1);
    checkOutput({tag, "_res_valid_clear"}, res_valid, 0);
  endtask

  initial begin
    int n;
    int sc;
    reset_n   = 1'b0;
    op_valid  = 1'b0;
    op_a      = '0;
    op_b      = '0;
    res_ready = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    checkOutput("rst_op_ready", op_ready, 1);
    checkOutput("rst_gcd_start", gcd_start, 0);
    checkOutput("rst_data_in", gcd_data_in, 0);
    checkOutput("rst_res_valid", res_valid, 0);
    checkOutput("rst_res_data", res_data, 0);
    checkOutput("rst_res_err", res_err, 0);

    applyStimulus(16'd78, 16'd143, 1'b0);
    waitResult("t1", n);
    checkOutput("t1_latency", n, ENG_DELAY + 4);
    checkOutput("t1_bus_a", eng_a, 78);
    checkOutput("t1_bus_b", eng_b, 143);
    consume("t1");

    // Engine still shows finish=1 with the old result 13 while the next pair is loaded.
    applyStimulus(16'd35, 16'd21, 1'b0);
    waitResult("t6_stale", n);
    checkOutput("t6_latency", n, ENG_DELAY + 4);
    consume("t6");

    sc = start_count;
    applyStimulus(16'd0, 16'd25, 1'b0);
    waitResult("t2_zero_a", n);
    checkOutput("t2_latency", n, 0);
    consume("t2a");
    applyStimulus(16'd0, 16'd0, 1'b0);
    waitResult("t2_zero_both", n);
    consume("t2b");
    applyStimulus(16'd40, 16'd0, 1'b0);
    waitResult("t2_zero_b", n);
    checkOutput("t2_latency_b", n, 0);
    consume("t2c");
    checkOutput("t2_no_start", start_count, sc);

    applyStimulus(16'd12, 16'd18, 1'b0);
    waitResult("t3", n);
    sc       = start_count;
    op_valid = 1'b1;
    op_a     = 16'd5;
    op_b     = 16'd10;
    repeat (10) begin
      @(negedge clock);
      checkOutput("bp_data", res_data, 6);
      checkOutput("bp_op_ready", op_ready, 0);
      checkOutput("bp_res_valid", res_valid, 1);
    end
    op_valid = 1'b0;
    checkOutput("bp_no_start", start_count, sc);
    consume("t3");
    @(negedge clock);
    checkOutput("bp_no_late_accept", res_valid, 0);

    applyStimulus(16'd100, 16'd75, 1'b0);
    repeat (4) @(negedge clock);
    reset_n = 1'b0;
    #1;
    checkOutput("t4_rst_op_ready", op_ready, 1);
    checkOutput("t4_rst_data_in", gcd_data_in, 0);
    checkOutput("t4_rst_res_valid", res_valid, 0);
    checkOutput("t4_rst_res_data", res_data, 0);
    checkOutput("t4_rst_res_err", res_err, 0);
    exp_q.delete();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (6) @(negedge clock);
    applyStimulus(16'd48, 16'd18, 1'b0);
    waitResult("t4_after_reset", n);
    consume("t4");

    for (int i = 0; i < 3; i++) begin
      applyStimulus(W'($urandom_range(1, 500)), W'($urandom_range(1, 500)), 1'b0);
      waitResult("rand", n);
      consume("rand");
    end

`ifdef GCD_SEQ_TIMEOUT_EN
    hold_finish_low = 1'b1;
    applyStimulus(16'd9, 16'd6, 1'b1);
    waitResult("t5_timeout", n);
    checkOutput("t5_latency", n, 12);
    consume("t5");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no end of test, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
